ps2_rx_fifo: RTL and testbench

Parametrised PS/2 device-to-host frame receiver for the keyboard path. It synchronises and glitch-filters the raw kbd_clk/kbd_dat lines and deserialises frames of the form start, DATA_BITS data (LSB first), odd parity, stop. It checks framing, parity and inter-bit timeout, and buffers good words in a show-ahead FIFO with a valid/read handshake to the downstream scancode decoder. Error pulses report bad frames.

---
 rtl/ps2_rx_fifo.sv | 179 +++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host frame receiver: synchronise and glitch-filter the raw lines,
// deserialise start/data/parity/stop frames and buffer good words in a show-ahead FIFO.
module ps2_rx_fifo #(
    parameter int DATA_BITS   = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_LEN    = 4,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic                          clk,
    input  logic                          resetN,
    input  logic                          kbd_clk,
    input  logic                          kbd_dat,
    input  logic                          rd_en,
    output logic [DATA_BITS-1:0]          dout,
    output logic                          dout_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          busy,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int BIT_W   = $clog2(DATA_BITS + 3);
    localparam int TIMER_W = $clog2(TIMEOUT_CYC + 1);
    localparam int FILT_W  = $clog2(FILT_LEN + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;

    localparam logic [BIT_W-1:0]   LAST_SHIFT   = BIT_W'(DATA_BITS + 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LAST = TIMER_W'(TIMEOUT_CYC);
    localparam logic [FILT_W-1:0]  FILT_LAST    = FILT_W'(FILT_LEN - 1);
    localparam logic [CNT_W-1:0]   DEPTH_C      = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_t;

    // Synchronisers idle high, matching the released PS/2 bus.
    logic [SYNC_STAGES-1:0] clk_sync, dat_sync;
    logic                   clk_s, dat_s;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
            for (int i = SYNC_STAGES - 1; i > 0; i--) begin
                clk_sync[i] <= clk_sync[i-1];
                dat_sync[i] <= dat_sync[i-1];
            end
            clk_sync[0] <= kbd_clk;
            dat_sync[0] <= kbd_dat;
        end
    end

    assign clk_s = clk_sync[SYNC_STAGES-1];
    assign dat_s = dat_sync[SYNC_STAGES-1];

    // fclk follows clk_s only after FILT_LEN consecutive differing samples.
    logic              fclk;
    logic [FILT_W-1:0] filt_cnt;
    logic              filt_done, sample_evt;

    assign filt_done  = (clk_s != fclk) && (filt_cnt == FILT_LAST);
    assign sample_evt = filt_done && fclk;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fclk     <= 1'b1;
            filt_cnt <= '0;
        end else if (clk_s == fclk) begin
            filt_cnt <= '0;
        end else if (filt_done) begin
            fclk     <= clk_s;
            filt_cnt <= '0;
        end else begin
            filt_cnt <= filt_cnt + 1'b1;
        end
    end

    // Frame FSM
    state_t               state, state_n;
    logic [BIT_W-1:0]     bit_cnt, bit_cnt_n;
    logic [TIMER_W-1:0]   timer, timer_n;
    logic [DATA_BITS:0]   shreg, shreg_n;
    logic                 stop_bit, stop_bit_n;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            timer    <= '0;
            shreg    <= '0;
            stop_bit <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            timer    <= timer_n;
            shreg    <= shreg_n;
            stop_bit <= stop_bit_n;
        end
    end

    always_comb begin
        // NOTE: every target gets a default first, so no path can infer a latch.
        state_n    = state;
        bit_cnt_n  = bit_cnt;
        timer_n    = timer;
        shreg_n    = shreg;
        stop_bit_n = stop_bit;
        unique case (state)
            IDLE: begin
                if (sample_evt && !dat_s) begin
                    bit_cnt_n = '0;
                    timer_n   = '0;
                    state_n   = SHIFT;
                end
            end
            SHIFT: begin
                if (timer == TIMEOUT_LAST) begin
                    state_n = IDLE;
                end else if (sample_evt) begin
                    timer_n   = '0;
                    bit_cnt_n = bit_cnt + 1'b1;
                    // The stop bit is held apart so data and parity stay aligned in shreg.
                    if (bit_cnt == LAST_SHIFT) begin
                        stop_bit_n = dat_s;
                        state_n    = CHECK;
                    end else begin
                        shreg_n = {dat_s, shreg[DATA_BITS:1]};
                    end
                end else begin
                    timer_n = timer + 1'b1;
                end
            end
            CHECK:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    logic in_check, frame_ok, full, pop, push;

    assign in_check   = (state == CHECK);
    assign frame_ok   = stop_bit && (^shreg);
    assign full       = (fifo_count == DEPTH_C);
    assign pop        = rd_en && dout_valid;
    assign push       = in_check && frame_ok && (!full || pop);

    assign busy       = (state != IDLE);
    assign parity_err = in_check && stop_bit && !(^shreg);
    assign frame_err  = (in_check && !stop_bit) || ((state == SHIFT) && (timer == TIMEOUT_LAST));
    assign overflow   = in_check && frame_ok && full && !pop;

    // Show-ahead FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr, rd_ptr;

    // NOTE: storage has no reset; the empty count masks stale contents on dout.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= shreg[DATA_BITS-1:0];
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      fifo_count <= fifo_count + 1'b1;
            else if (pop && !push) fifo_count <= fifo_count - 1'b1;
        end
    end

    assign dout_valid = (fifo_count != '0);
    assign dout       = dout_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: table-driven frames, hand-written FIFO/timeout/reset corners,
// and random frames scored against a queue model of the receive path.
module tb_ps2_rx_fifo;

    localparam int DB    = 8;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int FILT  = 4;
    localparam int TMO   = 200;
    localparam int HALF  = 20;

    logic          clk = 1'b0;
    logic          resetN;
    logic          kbd_clk, kbd_dat, rd_en;
    logic [DB-1:0] dout;
    logic          dout_valid, busy, parity_err, frame_err, overflow;
    logic [$clog2(DEPTH):0] fifo_count;

    ps2_rx_fifo #(
        .DATA_BITS(DB), .FIFO_DEPTH(DEPTH), .SYNC_STAGES(SYNC),
        .FILT_LEN(FILT), .TIMEOUT_CYC(TMO)
    ) dut (
        .clk(clk), .resetN(resetN), .kbd_clk(kbd_clk), .kbd_dat(kbd_dat), .rd_en(rd_en),
        .dout(dout), .dout_valid(dout_valid), .fifo_count(fifo_count), .busy(busy),
        .parity_err(parity_err), .frame_err(frame_err), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_perr = 0, n_ferr = 0, n_ovf = 0;
    int last_lat, lat_ref;
    logic dv_before;

    always @(negedge clk) begin
        if (parity_err) n_perr++;
        if (frame_err)  n_ferr++;
        if (overflow)   n_ovf++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One PS/2 bit: data set while the clock is high, device pulls the clock low.
    task automatic send_bit(input logic b, input bit glitch, input bit is_stop, input int pop_at);
        kbd_dat = b;
        for (int i = 0; i < HALF; i++) begin
            tick();
            kbd_clk = (glitch && i == HALF / 2) ? 1'b0 : 1'b1;
        end
        kbd_clk = 1'b0;
        for (int i = 1; i <= HALF; i++) begin
            tick();
            if (is_stop && last_lat == 0 && !dv_before && dout_valid) last_lat = i;
            rd_en   = is_stop && pop_at != 0 && i == pop_at - 1;
            kbd_clk = (glitch && i == HALF / 2) ? 1'b1 : 1'b0;
        end
        kbd_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [DB-1:0] d, input logic par, input logic stop,
                              input bit glitch, input int pop_at);
        last_lat = 0;
        send_bit(1'b0, glitch, 1'b0, 0);
        for (int i = 0; i < DB; i++) send_bit(d[i], glitch, 1'b0, 0);
        send_bit(par, glitch, 1'b0, 0);
        dv_before = dout_valid;
        send_bit(stop, glitch, 1'b1, pop_at);
        kbd_dat = 1'b1;
        repeat (HALF) tick();
    endtask

    task automatic pop_expect(input logic [DB-1:0] e, input string name);
        @(negedge clk);
        check({name, " valid"}, dout_valid, 1);
        check(name, dout, e);
        tick();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    function automatic logic odd_par(input logic [DB-1:0] d);
        return ~^d;
    endfunction

    typedef struct {
        logic [DB-1:0] data;
        logic          par;
        logic          stop;
        logic          exp_push;
        logic          exp_perr;
        logic          exp_ferr;
    } vec_t;

    vec_t vecs[9];
    logic [DB-1:0] exp_q[$];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int p0, f0, o0;
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'hF0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'hF0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

        resetN = 1'b0; kbd_clk = 1'b1; kbd_dat = 1'b1; rd_en = 1'b0;
        last_lat = 0; lat_ref = 0; dv_before = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        check("reset dout", dout, 0);
        check("reset dout_valid", dout_valid, 0);
        check("reset fifo_count", fifo_count, 0);
        check("reset busy", busy, 0);
        check("reset errs", {parity_err, frame_err, overflow}, 0);
        tick();
        resetN = 1'b1;
        repeat (10) tick();

        // Table-driven single frames
        for (int k = 0; k < 9; k++) begin
            p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
            send_frame(vecs[k].data, vecs[k].par, vecs[k].stop, 1'b0, 0);
            if (k == 0) begin
                lat_ref = last_lat;
                check("latency in range", (last_lat >= SYNC + FILT + 1) && (last_lat <= SYNC + FILT + 3), 1);
            end
            check($sformatf("vec%0d parity_err", k), n_perr - p0, vecs[k].exp_perr);
            check($sformatf("vec%0d frame_err", k), n_ferr - f0, vecs[k].exp_ferr);
            check($sformatf("vec%0d overflow", k), n_ovf - o0, 0);
            check($sformatf("vec%0d count", k), fifo_count, vecs[k].exp_push);
            if (vecs[k].exp_push) pop_expect(vecs[k].data, $sformatf("vec%0d dout", k));
            @(negedge clk);
            check($sformatf("vec%0d empty", k), dout_valid, 0);
        end
        if (lat_ref == 0) lat_ref = SYNC + FILT + 1;

        // Timeout mid-frame, then recovery
        f0 = n_ferr;
        send_bit(1'b0, 1'b0, 1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0, 1'b0, 0);
        @(negedge clk);
        check("timeout busy mid", busy, 1);
        check("timeout no early err", n_ferr - f0, 0);
        repeat (TMO + 10) tick();
        check("timeout frame_err", n_ferr - f0, 1);
        check("timeout busy fell", busy, 0);
        check("timeout no push", fifo_count, 0);
        send_frame(8'h32, odd_par(8'h32), 1'b1, 1'b0, 0);
        check("post-timeout count", fifo_count, 1);
        pop_expect(8'h32, "post-timeout dout");

        // Overflow when full
        o0 = n_ovf;
        for (int v = 1; v <= 5; v++) send_frame(DB'(v), odd_par(DB'(v)), 1'b1, 1'b0, 0);
        check("ovf count", fifo_count, DEPTH);
        check("ovf pulse", n_ovf - o0, 1);
        for (int v = 1; v <= 4; v++) pop_expect(DB'(v), $sformatf("ovf pop%0d", v));
        @(negedge clk);
        check("ovf drained", dout_valid, 0);

        // Full FIFO with a pop coinciding with the CHECK cycle
        for (int v = 1; v <= 4; v++) send_frame(DB'(v), odd_par(DB'(v)), 1'b1, 1'b0, 0);
        o0 = n_ovf;
        send_frame(8'h05, odd_par(8'h05), 1'b1, 1'b0, lat_ref);
        check("simul no overflow", n_ovf - o0, 0);
        check("simul count", fifo_count, DEPTH);
        for (int v = 2; v <= 5; v++) pop_expect(DB'(v), $sformatf("simul pop%0d", v));

        // Glitches on kbd_clk, then reset mid-frame
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'h55, odd_par(8'h55), 1'b1, 1'b0, 0);
        send_frame(8'h3C, odd_par(8'h3C), 1'b1, 1'b1, 0);
        check("glitch count", fifo_count, 2);
        check("glitch errs", (n_perr - p0) + (n_ferr - f0), 0);
        send_bit(1'b0, 1'b1, 1'b0, 0);
        for (int i = 0; i < 4; i++) send_bit(i[0], 1'b1, 1'b0, 0);
        resetN = 1'b0;
        tick();
        @(negedge clk);
        check("midreset dout", dout, 0);
        check("midreset valid", dout_valid, 0);
        check("midreset count", fifo_count, 0);
        check("midreset busy", busy, 0);
        check("midreset errs", {parity_err, frame_err, overflow}, 0);
        tick();
        resetN = 1'b1;
        kbd_dat = 1'b1;
        repeat (10) tick();
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'h2A, odd_par(8'h2A), 1'b1, 1'b0, 0);
        check("after reset count", fifo_count, 1);
        check("after reset errs", (n_perr - p0) + (n_ferr - f0), 0);
        pop_expect(8'h2A, "after reset dout");

        // Random frames against a queue model
        exp_q.delete();
        for (int k = 0; k < 40; k++) begin
            logic [DB-1:0] d;
            logic par, stop;
            int ep, ef, eo;
            d    = DB'($urandom);
            par  = ($urandom_range(0, 4) == 0) ? ~odd_par(d) : odd_par(d);
            stop = ($urandom_range(0, 9) != 0);
            p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
            ep = 0; ef = 0; eo = 0;
            send_frame(d, par, stop, 1'b0, 0);
            if (!stop)                  ef = 1;
            else if (^{d, par} == 1'b0) ep = 1;
            else if (exp_q.size() < DEPTH) exp_q.push_back(d);
            else                        eo = 1;
            check($sformatf("rnd%0d parity_err", k), n_perr - p0, ep);
            check($sformatf("rnd%0d frame_err", k), n_ferr - f0, ef);
            check($sformatf("rnd%0d overflow", k), n_ovf - o0, eo);
            check($sformatf("rnd%0d count", k), fifo_count, exp_q.size());
            if ($urandom_range(0, 2) == 0) begin
                if (exp_q.size() > 0) begin
                    pop_expect(exp_q.pop_front(), $sformatf("rnd%0d pop", k));
                end else begin
                    tick(); rd_en = 1'b1; tick(); rd_en = 1'b0;
                    @(negedge clk);
                    check($sformatf("rnd%0d empty pop", k), {dout_valid, fifo_count}, 0);
                end
            end
        end
        while (exp_q.size() > 0) pop_expect(exp_q.pop_front(), "rnd drain");
        @(negedge clk);
        check("rnd final empty", dout_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
